// File: rtl/covid_mem_pkg.sv
// rtl/covid_mem_pkg.sv - shared types and width helpers for the dual-port on-chip memory
package covid_mem_pkg;

  localparam int LAT_MAX = 2;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int mem_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/covid_ram_dp_core.sv
// rtl/covid_ram_dp_core.sv - true dual-port RAM, byte-lane writes, registered old-data reads
module covid_ram_dp_core
  import covid_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  localparam int BYTE_W = byte_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [BYTE_W-1:0] a_be,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_we,
  input  logic              b_re,
  input  logic [BYTE_W-1:0] b_be,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = mem_depth(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  // Callers keep a/b lanes disjoint on a shared address, so write order is irrelevant.
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int i = 0; i < BYTE_W; i++) begin
        if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
        if (b_we && b_be[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  // Read registers only load on a read, so they double as the first latency stage.
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (ce && a_re) a_rdata_d = mem[a_addr];
    if (ce && b_re) b_rdata_d = mem[b_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/covid_onchip_memory_dp.sv
// rtl/covid_onchip_memory_dp.sv - dual-port Avalon-MM on-chip RAM with clear FSM and read latency pipe
module covid_onchip_memory_dp
  import covid_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter int INIT_CLEAR   = 0,
  localparam int BYTE_W      = byte_lanes(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_req,
  input  logic              clken,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BYTE_W-1:0] s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BYTE_W-1:0] s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        v1_q, v1_d, last_v;
  logic [DATA_W-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
  logic [DATA_W-1:0] last_d1, last_d2, core_rd1, core_rd2;
  logic              en, busy, clearing;
  logic              s1_acc, s2_acc, s1_wr, s2_wr;
  logic [1:0]        rd_acc;
  logic [ADDR_W-1:0] a_addr;
  logic              a_we;
  logic [BYTE_W-1:0] a_be, b_be;
  logic [DATA_W-1:0] a_wdata;

  assign en       = clken & ~reset_req;
  assign busy     = ~en | (state_q == ST_CLEAR);
  assign clearing = en & (state_q == ST_CLEAR);

  assign s1_waitrequest = busy;
  assign s2_waitrequest = busy;

  // A combined read+write is a write only.
  assign s1_acc    = s1_chipselect & (s1_read | s1_write) & ~busy;
  assign s2_acc    = s2_chipselect & (s2_read | s2_write) & ~busy;
  assign s1_wr     = s1_acc & s1_write;
  assign s2_wr     = s2_acc & s2_write;
  assign rd_acc[0] = s1_acc & s1_read & ~s1_write;
  assign rd_acc[1] = s2_acc & s2_read & ~s2_write;

  assign a_addr  = clearing ? cnt_q : s1_address;
  assign a_we    = clearing | s1_wr;
  assign a_be    = clearing ? {BYTE_W{1'b1}} : s1_byteenable;
  assign a_wdata = clearing ? '0 : s1_writedata;
  assign b_be    = (s1_wr && (s1_address == s2_address)) ? (s2_byteenable & ~s1_byteenable)
                                                         : s2_byteenable;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v1_d    = en ? rd_acc : v1_q;
    hold1_d = s1_readdata;
    hold2_d = s2_readdata;
    if (clearing) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
      v1_q    <= '0;
      hold1_q <= '0;
      hold2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v1_q    <= v1_d;
      hold1_q <= hold1_d;
      hold2_q <= hold2_d;
    end
  end

  covid_ram_dp_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_core (
    .clk     (clk),
    .reset   (reset),
    .ce      (en),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_re    (rd_acc[0]),
    .a_be    (a_be),
    .a_wdata (a_wdata),
    .a_rdata (core_rd1),
    .b_addr  (s2_address),
    .b_we    (s2_wr),
    .b_re    (rd_acc[1]),
    .b_be    (b_be),
    .b_wdata (s2_writedata),
    .b_rdata (core_rd2)
  );

  if (READ_LATENCY >= LAT_MAX) begin : g_lat2
    logic [1:0]        v2_q, v2_d;
    logic [DATA_W-1:0] d1_q, d1_d, d2_q, d2_d;

    always_comb begin
      v2_d = en ? v1_q : v2_q;
      d1_d = (en && v1_q[0]) ? core_rd1 : d1_q;
      d2_d = (en && v1_q[1]) ? core_rd2 : d2_q;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q <= '0;
        d1_q <= '0;
        d2_q <= '0;
      end else begin
        v2_q <= v2_d;
        d1_q <= d1_d;
        d2_q <= d2_d;
      end
    end

    assign last_v  = v2_q;
    assign last_d1 = d1_q;
    assign last_d2 = d2_q;
  end else begin : g_lat1
    assign last_v  = v1_q;
    assign last_d1 = core_rd1;
    assign last_d2 = core_rd2;
  end

  // Valid is gated by en so a stalled word is presented exactly once, on the first live cycle.
  assign s1_readdatavalid = last_v[0] & en;
  assign s2_readdatavalid = last_v[1] & en;
  assign s1_readdata      = s1_readdatavalid ? last_d1 : hold1_q;
  assign s2_readdata      = s2_readdatavalid ? last_d2 : hold2_q;

endmodule

// File: tb/tb_covid_onchip_memory_dp.sv
// tb/tb_covid_onchip_memory_dp.sv - bench for covid_onchip_memory_dp at read latency 1 and 2
module tb_covid_onchip_memory_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset = 1'b1, reset_req = 1'b0, clken = 1'b1;
  logic [1:0]            cs = '0, rd = '0, wr = '0;
  logic [1:0][9:0]       addr = '0;
  logic [1:0][3:0]       be = '0;
  logic [1:0][31:0]      wd = '0;
  logic [1:0][1:0][31:0] rdata;
  logic [1:0][1:0]       rvalid, wreq;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    covid_onchip_memory_dp #(.DATA_W(32), .ADDR_W(10), .READ_LATENCY(d + 1), .INIT_CLEAR(1)) u_dut (
      .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
      .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
      .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[d][0]),
      .s1_readdatavalid(rvalid[d][0]), .s1_waitrequest(wreq[d][0]),
      .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
      .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[d][1]),
      .s2_readdatavalid(rvalid[d][1]), .s2_waitrequest(wreq[d][1])
    );
  end

  typedef struct { logic [31:0] data; int age; } rd_t;
  typedef struct { logic [9:0] addr; logic [3:0] be; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  // Reference model: word array plus per-(latency,port) queue of words awaiting delivery.
  logic [31:0] exp_mem [1024];
  rd_t         pend [4][$];
  logic [31:0] last_d [4];
  logic [31:0] seen_d [4];
  int          seen_n [4];
  int          clear_left = 0;
  int          n_cmp = 0, n_fail = 0;

  function automatic void chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d] got=%h exp=%h t=%0t", name, idx, got, exp, $time);
    end
  endfunction

  task automatic check_cycle();
    logic en;
    en = clken & ~reset_req;
    for (int i = 0; i < 4; i++) begin
      int d;
      int p;
      logic expv;
      logic [31:0] expd;
      d = i / 2;
      p = i % 2;
      expv = en && pend[i].size() > 0 && pend[i][0].age == d + 1;
      expd = last_d[i];
      if (expv) expd = pend[i][0].data;
      chk("waitrequest", i, 32'(wreq[d][p]), 32'(!en || clear_left > 0));
      chk("readdatavalid", i, 32'(rvalid[d][p]), 32'(expv));
      chk("readdata", i, rdata[d][p], expd);
      if (rvalid[d][p] === 1'b1) begin
        seen_n[i]++;
        seen_d[i] = rdata[d][p];
      end
    end
  endtask

  task automatic model_edge();
    rd_t r;
    if (reset) begin
      clear_left = 1024;
      for (int i = 0; i < 4; i++) begin
        pend[i].delete();
        last_d[i] = '0;
      end
      return;
    end
    if (!(clken && !reset_req)) return;
    for (int i = 0; i < 4; i++) begin
      if (pend[i].size() > 0 && pend[i][0].age == i / 2 + 1) begin
        last_d[i] = pend[i][0].data;
        void'(pend[i].pop_front());
      end
      for (int j = 0; j < pend[i].size(); j++) pend[i][j].age++;
    end
    if (clear_left > 0) begin
      exp_mem[1024 - clear_left] = '0;
      clear_left--;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if (cs[p] && rd[p] && !wr[p]) begin
        r.data = exp_mem[addr[p]];
        r.age  = 1;
        pend[p].push_back(r);
        pend[p + 2].push_back(r);
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (cs[p] && wr[p]) begin
        for (int l = 0; l < 4; l++)
          if (be[p][l]) exp_mem[addr[p]][8*l +: 8] = wd[p][8*l +: 8];
      end
    end
  endtask

  task automatic tick(bit do_check = 1'b1);
    @(negedge clk);
    if (do_check) check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = '0;
    rd = '0;
    wr = '0;
  endtask

  task automatic op(int p, bit r, bit w, logic [9:0] a, logic [3:0] b, logic [31:0] d);
    cs[p]   = 1'b1;
    rd[p]   = r;
    wr[p]   = w;
    addr[p] = a;
    be[p]   = b;
    wd[p]   = d;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < 4; i++) begin
      seen_n[i] = 0;
      seen_d[i] = 32'hDEAD_DEAD;
    end
  endtask

  task automatic read_check(string name, int p, logic [9:0] a, logic [31:0] exp);
    clear_seen();
    idle();
    op(p, 1'b1, 1'b0, a, 4'h0, 32'h0);
    tick();
    idle();
    for (int k = 0; k < 8 && (seen_n[p] == 0 || seen_n[p + 2] == 0); k++) tick();
    for (int d = 0; d < 2; d++) begin
      if (seen_n[p + 2*d] == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s lat%0d readdatavalid never seen, required one pulse", name, d + 1);
      end else begin
        chk(name, p + 2*d, seen_d[p + 2*d], exp);
      end
    end
  endtask

  task automatic count_clear(string name);
    int n;
    n = 0;
    while (wreq[0][0] === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk(name, 0, 32'(n), 32'd1024);
  endtask

  initial begin
    vec_t vt [5];
    vt[0] = '{10'h3A5, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[1] = '{10'h010, 4'b1111, 32'h11111111, 32'h11111111};
    vt[2] = '{10'h3A5, 4'b0011, 32'h1234CAFE, 32'hDEADCAFE};
    vt[3] = '{10'h3A5, 4'b0000, 32'hFFFFFFFF, 32'hDEADCAFE};
    vt[4] = '{10'h000, 4'b1000, 32'hA5A5A5A5, 32'hA5000000};
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    for (int i = 0; i < 4; i++) last_d[i] = '0;
    clear_seen();

    reset = 1'b1;
    tick(1'b0);
    tick();
    reset = 1'b0;
    count_clear("initial_clear_cycles");
    read_check("read_3ff_after_clear", 0, 10'h3FF, 32'h0);

    for (int i = 0; i < 5; i++) begin
      idle();
      op(0, 1'b0, 1'b1, vt[i].addr, vt[i].be, vt[i].wdata);
      tick();
      read_check("table_readback", 0, vt[i].addr, vt[i].exp);
    end

    idle();
    op(0, 1'b0, 1'b1, 10'h010, 4'b1100, 32'h11111111);
    op(1, 1'b0, 1'b1, 10'h010, 4'b0110, 32'h22222222);
    tick();
    read_check("dual_write_collision", 1, 10'h010, 32'h11112211);

    clear_seen();
    idle();
    op(0, 1'b0, 1'b1, 10'h020, 4'hF, 32'hAAAA5555);
    op(1, 1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
    tick();
    idle();
    repeat (3) tick();
    chk("xport_old_data_l1", 1, seen_d[1], 32'h0);
    chk("xport_old_data_l2", 3, seen_d[3], 32'h0);
    read_check("xport_new_data", 1, 10'h020, 32'hAAAA5555);

    idle();
    op(1, 1'b0, 1'b1, 10'h001, 4'hF, 32'h01010101);
    tick();
    op(1, 1'b0, 1'b1, 10'h002, 4'hF, 32'h02020202);
    tick();
    clear_seen();
    for (int a = 0; a < 3; a++) begin
      op(1, 1'b1, 1'b0, 10'(a), 4'h0, 32'h0);
      tick();
    end
    idle();
    repeat (4) tick();
    chk("b2b_pulses_l1", 1, 32'(seen_n[1]), 32'd3);
    chk("b2b_pulses_l2", 3, 32'(seen_n[3]), 32'd3);
    chk("b2b_last_word_l2", 3, seen_d[3], 32'h02020202);

    clear_seen();
    idle();
    op(0, 1'b1, 1'b0, 10'h3A5, 4'h0, 32'h0);
    tick();
    idle();
    clken = 1'b0;
    repeat (3) tick();
    clken = 1'b1;
    repeat (3) tick();
    chk("stall_pulses_l1", 0, 32'(seen_n[0]), 32'd1);
    chk("stall_pulses_l2", 2, 32'(seen_n[2]), 32'd1);
    chk("stall_data_l1", 0, seen_d[0], 32'hDEADCAFE);

    repeat (1500) begin
      idle();
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0)
          op(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)),
             4'($urandom), $urandom);
        cs[p] = cs[p] & ($urandom_range(0, 7) != 0);
      end
      clken     = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    clken     = 1'b1;
    reset_req = 1'b0;
    repeat (4) tick();

    op(0, 1'b0, 1'b1, 10'h3FF, 4'hF, 32'hFFFFFFFF);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (500) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_clear("restart_clear_cycles");
    read_check("read_3ff_after_reclear", 0, 10'h3FF, 32'h0);
    read_check("read_3a5_after_reclear", 1, 10'h3A5, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
